// File: rtl/be_dctrl_exmem.sv
// Decode-stage jump/branch control, data-memory byte-enable generation and
// the EX/MEM pipeline register bank with HI/LO forwarding into the ALU result slot.
module be_dctrl_exmem (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] ins_D,
  output logic        j,
  output logic        jal,
  output logic        jr,
  output logic        branch,
  output logic        extOp,
  output logic [2:0]  cmpOp,
  input  logic [1:0]  A,
  input  logic [1:0]  BE_Op,
  output logic [3:0]  BE_M,
  input  logic [31:0] ins_E,
  input  logic [31:0] pc_E,
  input  logic [31:0] RData2_E,
  input  logic [31:0] alu_Result_E,
  input  logic [31:0] HI_E,
  input  logic [31:0] LO_E,
  output logic [31:0] ins_M,
  output logic [31:0] pc_M,
  output logic [31:0] RData2_M,
  output logic [31:0] alu_Result_M
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;
  localparam logic [5:0] FN_MFHI    = 6'b010000;
  localparam logic [5:0] FN_MFLO    = 6'b010010;

  localparam logic [4:0] RT_BLTZ    = 5'b00000;
  localparam logic [4:0] RT_BGEZ    = 5'b00001;

  logic [5:0]  w_op_d;
  logic [5:0]  w_fn_d;
  logic [4:0]  w_rt_d;
  logic [5:0]  w_op_e;
  logic [5:0]  w_fn_e;
  logic [31:0] w_alu_sel;

  logic [31:0] r_ins_m;
  logic [31:0] r_pc_m;
  logic [31:0] r_rdata2_m;
  logic [31:0] r_alu_m;

  assign w_op_d = ins_D[31:26];
  assign w_fn_d = ins_D[5:0];
  assign w_rt_d = ins_D[20:16];

  // Decode-stage control: purely combinational, independent of the pipeline registers.
  always_comb begin
    j      = 1'b0;
    jal    = 1'b0;
    jr     = 1'b0;
    branch = 1'b0;
    cmpOp  = 3'b000;
    extOp  = 1'b1;
    case (w_op_d)
      OP_J: j = 1'b1;
      OP_JAL: begin
        j   = 1'b1;
        jal = 1'b1;
      end
      OP_SPECIAL: begin
        if (w_fn_d == FN_JR || w_fn_d == FN_JALR) begin
          jr = 1'b1;
        end
      end
      OP_BEQ: begin
        branch = 1'b1;
        cmpOp  = 3'b000;
      end
      OP_BNE: begin
        branch = 1'b1;
        cmpOp  = 3'b001;
      end
      OP_BLEZ: begin
        branch = 1'b1;
        cmpOp  = 3'b010;
      end
      OP_BGTZ: begin
        branch = 1'b1;
        cmpOp  = 3'b011;
      end
      OP_REGIMM: begin
        if (w_rt_d == RT_BLTZ) begin
          branch = 1'b1;
          cmpOp  = 3'b100;
        end else if (w_rt_d == RT_BGEZ) begin
          branch = 1'b1;
          cmpOp  = 3'b101;
        end
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: extOp = 1'b0;
      default: ;
    endcase
  end

  // Halfword enables follow A[1] only; a misaligned halfword is not trapped here.
  always_comb begin
    BE_M = 4'b0000;
    case (BE_Op)
      2'b00: BE_M = 4'b1111;
      2'b01: BE_M = A[1] ? 4'b1100 : 4'b0011;
      2'b10: BE_M = 4'b0001 << A;
      default: BE_M = 4'b0000;
    endcase
  end

  assign w_op_e = ins_E[31:26];
  assign w_fn_e = ins_E[5:0];

  always_comb begin
    w_alu_sel = alu_Result_E;
    if (w_op_e == OP_SPECIAL && w_fn_e == FN_MFHI) begin
      w_alu_sel = HI_E;
    end else if (w_op_e == OP_SPECIAL && w_fn_e == FN_MFLO) begin
      w_alu_sel = LO_E;
    end
  end

  // Reset takes priority over the hold so a stall cannot preserve a flushed instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ins_m    <= 32'h0;
      r_pc_m     <= 32'h0;
      r_rdata2_m <= 32'h0;
      r_alu_m    <= 32'h0;
    end else if (!en) begin
      r_ins_m    <= ins_E;
      r_pc_m     <= pc_E;
      r_rdata2_m <= RData2_E;
      r_alu_m    <= w_alu_sel;
    end
  end

  assign ins_M        = r_ins_m;
  assign pc_M         = r_pc_m;
  assign RData2_M     = r_rdata2_m;
  assign alu_Result_M = r_alu_m;

endmodule

// File: tb/tb_be_dctrl_exmem.sv
// Directed bench for be_dctrl_exmem: decoder, byte enables and EX/MEM register bank.
module tb_be_dctrl_exmem;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] ins_D;
  logic        j;
  logic        jal;
  logic        jr;
  logic        branch;
  logic        extOp;
  logic [2:0]  cmpOp;
  logic [1:0]  A;
  logic [1:0]  BE_Op;
  logic [3:0]  BE_M;
  logic [31:0] ins_E;
  logic [31:0] pc_E;
  logic [31:0] RData2_E;
  logic [31:0] alu_Result_E;
  logic [31:0] HI_E;
  logic [31:0] LO_E;
  logic [31:0] ins_M;
  logic [31:0] pc_M;
  logic [31:0] RData2_M;
  logic [31:0] alu_Result_M;

  int n_cmp;
  int n_fail;

  be_dctrl_exmem dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .ins_D        (ins_D),
    .j            (j),
    .jal          (jal),
    .jr           (jr),
    .branch       (branch),
    .extOp        (extOp),
    .cmpOp        (cmpOp),
    .A            (A),
    .BE_Op        (BE_Op),
    .BE_M         (BE_M),
    .ins_E        (ins_E),
    .pc_E         (pc_E),
    .RData2_E     (RData2_E),
    .alu_Result_E (alu_Result_E),
    .HI_E         (HI_E),
    .LO_E         (LO_E),
    .ins_M        (ins_M),
    .pc_M         (pc_M),
    .RData2_M     (RData2_M),
    .alu_Result_M (alu_Result_M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decoder outputs packed as {j, jal, jr, branch, extOp, cmpOp}.
  function automatic logic [31:0] dec_vec();
    return {24'h0, j, jal, jr, branch, extOp, cmpOp};
  endfunction

  function automatic logic [31:0] mk_dec(input logic vj, input logic vjal, input logic vjr,
                                         input logic vbr, input logic vext, input logic [2:0] vcmp);
    return {24'h0, vj, vjal, vjr, vbr, vext, vcmp};
  endfunction

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst = 1'b1; en = 1'b0; ins_D = 32'h0; A = 2'd0; BE_Op = 2'b00;
    ins_E = 32'h00221820; pc_E = 32'h3000; RData2_E = 32'h55AA; alu_Result_E = 32'h77;
    HI_E = 32'h1; LO_E = 32'h2;

    // Reset state
    tick();
    check("rst_ins_M", ins_M, 32'h0);
    check("rst_pc_M", pc_M, 32'h0);
    check("rst_rdata2_M", RData2_M, 32'h0);
    check("rst_alu_M", alu_Result_M, 32'h0);
    rst = 1'b0;

    // Decoder vectors
    ins_D = 32'h0C000010; #1; check("dec_jal", dec_vec(), mk_dec(1, 1, 0, 0, 1, 3'b000));
    ins_D = 32'h08000004; #1; check("dec_j", dec_vec(), mk_dec(1, 0, 0, 0, 1, 3'b000));
    ins_D = 32'h04010003; #1; check("dec_bgez", dec_vec(), mk_dec(0, 0, 0, 1, 1, 3'b101));
    ins_D = 32'h04000003; #1; check("dec_bltz", dec_vec(), mk_dec(0, 0, 0, 1, 1, 3'b100));
    ins_D = 32'h34210001; #1; check("dec_ori", dec_vec(), mk_dec(0, 0, 0, 0, 0, 3'b000));
    ins_D = 32'h3C010001; #1; check("dec_lui", dec_vec(), mk_dec(0, 0, 0, 0, 0, 3'b000));
    ins_D = 32'h03E00008; #1; check("dec_jr", dec_vec(), mk_dec(0, 0, 1, 0, 1, 3'b000));
    ins_D = 32'h0060F809; #1; check("dec_jalr", dec_vec(), mk_dec(0, 0, 1, 0, 1, 3'b000));
    ins_D = 32'h10220005; #1; check("dec_beq", dec_vec(), mk_dec(0, 0, 0, 1, 1, 3'b000));
    ins_D = 32'h14220005; #1; check("dec_bne", dec_vec(), mk_dec(0, 0, 0, 1, 1, 3'b001));
    ins_D = 32'h18200005; #1; check("dec_blez", dec_vec(), mk_dec(0, 0, 0, 1, 1, 3'b010));
    ins_D = 32'h1C200005; #1; check("dec_bgtz", dec_vec(), mk_dec(0, 0, 0, 1, 1, 3'b011));
    ins_D = 32'h04020003; #1; check("dec_regimm_other", dec_vec(), mk_dec(0, 0, 0, 0, 1, 3'b000));
    ins_D = 32'h00000000; #1; check("dec_nop", dec_vec(), mk_dec(0, 0, 0, 0, 1, 3'b000));

    // Byte enables
    BE_Op = 2'b10; A = 2'd2; #1; check("be_byte_a2", {28'h0, BE_M}, 32'h4);
    BE_Op = 2'b10; A = 2'd0; #1; check("be_byte_a0", {28'h0, BE_M}, 32'h1);
    BE_Op = 2'b10; A = 2'd3; #1; check("be_byte_a3", {28'h0, BE_M}, 32'h8);
    BE_Op = 2'b01; A = 2'd2; #1; check("be_half_a2", {28'h0, BE_M}, 32'hC);
    BE_Op = 2'b01; A = 2'd1; #1; check("be_half_a1", {28'h0, BE_M}, 32'h3);
    BE_Op = 2'b01; A = 2'd3; #1; check("be_half_a3", {28'h0, BE_M}, 32'hC);
    BE_Op = 2'b00; A = 2'd3; #1; check("be_word_a3", {28'h0, BE_M}, 32'hF);
    BE_Op = 2'b11; A = 2'd1; #1; check("be_none", {28'h0, BE_M}, 32'h0);

    // HI/LO forwarding into alu_Result_M
    en = 1'b0; ins_E = 32'h00001010; HI_E = 32'h12345678; LO_E = 32'hCAFEBABE;
    alu_Result_E = 32'h0000DEAD; pc_E = 32'h3000; RData2_E = 32'hA5A5A5A5;
    tick();
    check("mfhi_alu_M", alu_Result_M, 32'h12345678);
    check("mfhi_ins_M", ins_M, 32'h00001010);
    check("mfhi_rdata2_M", RData2_M, 32'hA5A5A5A5);
    ins_E = 32'h00001012;
    tick();
    check("mflo_alu_M", alu_Result_M, 32'hCAFEBABE);
    ins_E = 32'h00221820;
    tick();
    check("add_alu_M", alu_Result_M, 32'h0000DEAD);

    // Hold behaviour
    pc_E = 32'h3004;
    tick();
    check("load_pc_M", pc_M, 32'h3004);
    en = 1'b1; pc_E = 32'h3008; ins_E = 32'h00001010; RData2_E = 32'h1111;
    tick();
    check("hold_pc_M", pc_M, 32'h3004);
    check("hold_ins_M", ins_M, 32'h00221820);
    check("hold_rdata2_M", RData2_M, 32'hA5A5A5A5);
    check("hold_alu_M", alu_Result_M, 32'h0000DEAD);
    en = 1'b0;
    tick();
    check("release_pc_M", pc_M, 32'h3008);
    check("release_alu_M", alu_Result_M, 32'h12345678);

    // Reset wins over hold
    rst = 1'b1; en = 1'b1; pc_E = 32'h400C; ins_E = 32'h8C220004;
    tick();
    check("rst_hold_ins_M", ins_M, 32'h0);
    check("rst_hold_pc_M", pc_M, 32'h0);
    check("rst_hold_rdata2_M", RData2_M, 32'h0);
    check("rst_hold_alu_M", alu_Result_M, 32'h0);
    rst = 1'b0; en = 1'b0;
    tick();
    check("post_rst_pc_M", pc_M, 32'h400C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
